// File: rtl/irq_ctrl.sv
// irq_ctrl: 4-source edge-triggered interrupt controller with PEND/MASK/CAUSE/EOI registers on the user-memory bus
module irq_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq_in,
  input  logic       bus_rw,
  input  logic [7:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       interrupt,
  output logic [1:0] irq_id,
  output logic       in_service
);
  typedef enum logic {IDLE, SERVICE} state_t;
  state_t state, state_nx;
  logic [3:0] pend, mask, prev, edges, ready, clr_dispatch, clr_bus;
  logic [7:0] off;
  logic [1:0] reg_sel, low_id;
  logic hit, wr_pend, wr_mask, eoi, dispatch;
  assign off     = bus_addr - BASE_ADDR;
  assign hit     = off[7:2] == 6'd0;
  assign reg_sel = off[1:0];
  assign wr_pend = bus_rw && hit && reg_sel == 2'd0;
  assign wr_mask = bus_rw && hit && reg_sel == 2'd1;
  assign eoi     = bus_rw && hit && reg_sel == 2'd3;
  assign edges   = irq_in & ~prev;
  assign ready   = pend & mask;
  assign low_id  = ready[0] ? 2'd0 : ready[1] ? 2'd1 : ready[2] ? 2'd2 : 2'd3;
  assign clr_dispatch = dispatch ? 4'b0001 << low_id : 4'b0000;
  assign clr_bus      = wr_pend ? bus_wdata[3:0] : 4'b0000;
  always_comb begin
    dispatch = (state == IDLE) && |ready;
    state_nx = dispatch ? SERVICE : ((state == SERVICE) && eoi) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // new edges are ORed in last so a set always beats any clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev       <= 4'h0;
      pend       <= 4'h0;
      mask       <= 4'h0;
      irq_id     <= 2'd0;
      interrupt  <= 1'b0;
      in_service <= 1'b0;
    end else begin
      prev       <= irq_in;
      pend       <= (pend & ~clr_dispatch & ~clr_bus) | edges;
      mask       <= wr_mask ? bus_wdata[3:0] : mask;
      irq_id     <= dispatch ? low_id : irq_id;
      interrupt  <= dispatch;
      in_service <= state_nx == SERVICE;
    end
  end
  always_comb
    bus_rdata = (bus_rw || !hit) ? 8'h00 :
                reg_sel == 2'd0 ? {4'h0, pend} :
                reg_sel == 2'd1 ? {4'h0, mask} :
                reg_sel == 2'd2 ? {in_service, 5'b0, irq_id} : 8'h00;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scoreboard bench for irq_ctrl; expected reads and interrupt pulses are queued by stimulus and popped by a monitor
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_in = 4'h0;
  logic       bus_rw = 1'b0;
  logic [7:0] bus_addr = 8'h00;
  logic [7:0] bus_wdata = 8'h00;
  logic [7:0] bus_rdata;
  logic       interrupt;
  logic [1:0] irq_id;
  logic       in_service;
  typedef struct {logic [1:0] id; int cyc;} irq_t;
  irq_t irq_q[$];
  logic [7:0] rd_q[$];
  logic rd_req = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  irq_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .bus_rw(bus_rw), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .interrupt(interrupt), .irq_id(irq_id),
    .in_service(in_service)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rd_req) chk("bus_rdata", int'(bus_rdata), int'(rd_q.pop_front()));
    if (interrupt) begin
      if (irq_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_interrupt: got irq_id %0d expected no pulse at cycle %0d", irq_id, cyc);
      end else begin
        irq_t e;
        e = irq_q.pop_front();
        chk("irq_id", int'(irq_id), int'(e.id));
        chk("irq_cycle", cyc, e.cyc);
        chk("irq_in_service", int'(in_service), 1);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_rw = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_rw = 1'b0; bus_addr = 8'h00; bus_wdata = 8'h00;
  endtask
  task automatic rd(input logic rw, input logic [7:0] a, input logic [7:0] exp);
    bus_rw = rw; bus_addr = a; bus_wdata = 8'h00;
    rd_q.push_back(exp);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0; bus_rw = 1'b0; bus_addr = 8'h00;
  endtask
  task automatic expect_irq(input logic [1:0] id, input int at);
    irq_t e;
    e.id = id; e.cyc = at;
    irq_q.push_back(e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end
  initial begin
    #12 reset = 1'b0;
    tick();
    rd(1'b0, 8'hF0, 8'h00);
    rd(1'b0, 8'hF1, 8'h00);
    rd(1'b0, 8'hF2, 8'h00);
    rd(1'b0, 8'h10, 8'h00);
    rd(1'b1, 8'hF1, 8'h00);
    // priority dispatch: bits 1 and 3 together, bit 1 wins
    wr(8'hF1, 8'hFF);
    rd(1'b0, 8'hF1, 8'h0F);
    expect_irq(2'd1, cyc + 2);
    irq_in = 4'b1010;
    tick();
    tick();
    rd(1'b0, 8'hF0, 8'h08);
    rd(1'b0, 8'hF2, 8'h81);
    // EOI chains to the remaining pending bit 3
    expect_irq(2'd3, cyc + 2);
    wr(8'hF3, 8'h00);
    tick();
    rd(1'b0, 8'hF0, 8'h00);
    rd(1'b0, 8'hF2, 8'h83);
    wr(8'hF3, 8'h00);
    rd(1'b0, 8'hF2, 8'h03);
    irq_in = 4'h0;
    tick();
    wr(8'hF3, 8'h00);
    rd(1'b0, 8'hF2, 8'h03);
    rd(1'b0, 8'hF1, 8'h0F);
    // masked source stays pending until enabled
    wr(8'hF1, 8'h00);
    irq_in = 4'b0100;
    tick();
    tick();
    tick();
    rd(1'b0, 8'hF0, 8'h04);
    expect_irq(2'd2, cyc + 2);
    wr(8'hF1, 8'h04);
    tick();
    rd(1'b0, 8'hF2, 8'h82);
    rd(1'b0, 8'hF0, 8'h00);
    wr(8'hF3, 8'h00);
    irq_in = 4'h0;
    tick();
    // set beats write-1-to-clear on the same bit
    irq_in = 4'b0001;
    wr(8'hF0, 8'h01);
    rd(1'b0, 8'hF0, 8'h01);
    expect_irq(2'd0, cyc + 2);
    wr(8'hF1, 8'h01);
    tick();
    rd(1'b0, 8'hF2, 8'h80);
    irq_in = 4'h0; tick();
    irq_in = 4'h1; tick();
    irq_in = 4'h0; tick();
    irq_in = 4'h1; tick();
    rd(1'b0, 8'hF0, 8'h01);
    expect_irq(2'd0, cyc + 2);
    wr(8'hF3, 8'h00);
    tick();
    rd(1'b0, 8'hF0, 8'h00);
    rd(1'b0, 8'hF2, 8'h80);
    // async reset in SERVICE with everything pending
    wr(8'hF1, 8'h0F);
    irq_in = 4'h0; tick();
    irq_in = 4'hF; tick();
    rd(1'b0, 8'hF0, 8'h0F);
    rd(1'b0, 8'hF1, 8'h0F);
    reset = 1'b1;
    bus_addr = 8'hF0;
    #1;
    chk("rst_in_service", int'(in_service), 0);
    chk("rst_interrupt", int'(interrupt), 0);
    chk("rst_pend", int'(bus_rdata), 0);
    bus_addr = 8'hF1;
    #1;
    chk("rst_mask", int'(bus_rdata), 0);
    bus_addr = 8'h00;
    reset = 1'b0;
    tick();
    rd(1'b0, 8'hF0, 8'h0F);
    // reset during an interrupt pulse drops it before the monitor samples it
    wr(8'hF1, 8'h0F);
    tick();
    chk("pulse_before_reset", int'(interrupt), 1);
    reset = 1'b1;
    #1;
    chk("pulse_reset_interrupt", int'(interrupt), 0);
    chk("pulse_reset_in_service", int'(in_service), 0);
    #6 reset = 1'b0;
    tick();
    tick();
    chk("irq_queue_left", irq_q.size(), 0);
    chk("rd_queue_left", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 8'hF0, is the base of the 4-register window on the user-memory bus.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 irq_in  input  4  raw level interrupt sources; a rising edge requests service.
REQ-005 bus_rw  input  1  1 = write, 0 = read; same encoding as the control block's rw.
REQ-006 bus_addr  input  8  user-memory address; the control block's usermem_address.
REQ-007 bus_wdata  input  8  write data; the control block's usermem_data_out.
REQ-008 bus_rdata  output  8  read data, merged into the control block's usermem_data_in.
REQ-009 interrupt  output  1  registered one-cycle request pulse to the control block.
REQ-010 irq_id  output  2  index of the source currently in service.
REQ-011 in_service  output  1  high from dispatch until EOI.

Function
REQ-012 Register map:
- BASE+0 PEND: read-only bits [3:0]; write-1-to-clear.
- BASE+1 MASK: R/W bits [3:0]; 1 = enabled.
- BASE+2 CAUSE: read-only, {in_service, 5'b0, irq_id}.
- BASE+3 EOI: write-only; any write ends service.
REQ-013 Unused register bits shall read 0, and register bits 7:4 shall be ignored on write.
REQ-014 bus_rdata shall be combinational: it shows the addressed register when bus_rw=0, and is 8'h00 for unmapped addresses, EOI reads, or bus_rw=1.
REQ-015 Edge detect: prev[i] shall be registered each cycle, and pend[i] shall be set on the clock where irq_in[i]=1 and prev[i]=0.
REQ-016 When a PEND write-1-to-clear and a new edge hit the same bit in one cycle, set shall win.
REQ-017 pend bits shall set regardless of MASK; masking only gates dispatch.
REQ-018 While a bit is already pending, further edges on it are lost, giving one level of queueing per source.
REQ-019 FSM states are IDLE and SERVICE.
REQ-020 IDLE -> SERVICE when (pend & mask) != 0. On that edge:
- irq_id <= lowest set index (bit 0 has highest priority);
- pend[irq_id] is cleared;
- interrupt <= 1;
- in_service <= 1.
REQ-021 interrupt shall be high for exactly one cycle per dispatch and shall return to 0 on the next edge.
REQ-022 SERVICE -> IDLE on an EOI write; in_service <= 0 on that edge, and irq_id holds its value.
REQ-023 In SERVICE no new dispatch occurs; new edges only set pend.
REQ-024 Latency: an edge sampled at clock k sets pend at k; the dispatch decision is made at k+1; interrupt is high during cycle k+2.
REQ-025 After EOI at clock j, a still-pending enabled bit shall dispatch at clock j+1; back-to-back pulses are at least 2 cycles apart.
REQ-026 A MASK write shall take effect for the dispatch decision on the following clock, not the same one.
REQ-027 An EOI write while in IDLE shall have no effect.
REQ-028 A PEND or MASK write in the same cycle as a dispatch shall apply its effect after the dispatch clear, and shall not cancel the dispatch.

Reset
REQ-029 On reset assertion, asynchronously:
- pend, mask, prev, irq_id <= 0;
- interrupt, in_service <= 0;
- state <= IDLE.
REQ-030 Reset asserted mid-SERVICE or during an interrupt pulse shall drop interrupt and in_service at once and discard all pending requests.
REQ-031 Sources already high when reset deasserts shall register as edges, because prev resets to 0.

Verification
REQ-032 Priority dispatch: MASK=4'hF, then irq_in 0->4'b1010 at clock k -> interrupt high during cycle k+2, irq_id=1, PEND reads 4'b1000.
REQ-033 Chained service: from the REQ-032 state, write EOI at clock j -> interrupt high during cycle j+2 with irq_id=3, PEND reads 0, CAUSE reads 8'h83.
REQ-034 Masked source: MASK=0, edge on bit 2 -> no interrupt, PEND=4'b0100; write MASK=4'h4 -> interrupt pulse after 2 cycles with irq_id=2.
REQ-035 Set-vs-clear collision: write PEND=4'h1 in the same cycle as a new edge on bit 0 -> PEND still reads 4'h1; in SERVICE, a second edge on bit 0 leaves a single pending bit.
REQ-036 Async reset: assert reset mid-cycle while in SERVICE with PEND=4'hF -> interrupt, in_service, PEND, MASK all 0 before the next clock edge.
